tpu_seq: RTL
============

// Module: tpu_seq
// PURPOSE
//  Memory-mapped sequencer for the TPU datapath (memA, memB, systolic_array).
//  Decodes host bus writes and reads into A-row loads, B-row pushes and C-row reads and writes.
//  A START command runs one matmul autonomously; a busy/done/error status and a done interrupt are provided.
//  Sits between the host bus and the datapath, replacing the hand-driven strobes of the first-generation top.
// PARAMETERS
//  BITS_AB 8   A/B element width
//  BITS_C  16  C element width
//  DIM     8   array dimension; must be >= 2
//  ADDRW   16  bus address width (word address)
//  DATAW   64  bus data width; must equal DIM*BITS_AB
// PORTS
//  clk      in  1             clock
//  rst_n    in  1             reset, synchronous, active-low
//  bus_en   in  1             bus transaction strobe, one cycle per access
//  r_w      in  1             0=read, 1=write
//  addr     in  ADDRW         word address
//  dataIn   in  DATAW         write data
//  dataOut  out DATAW         read data
//  rd_valid out 1             dataOut valid
//  irq_done out 1             level interrupt: DONE & IRQ_EN
//  a_en, a_wren   out 1       memA shift-out enable / row write enable
//  a_row    out $clog2(DIM)   memA row index
//  a_din    out DIM*BITS_AB   memA row data
//  b_en     out 1             memB push/shift enable
//  b_din    out DIM*BITS_AB   memB row data
//  sa_en, sa_wren out 1       array compute enable / C row write enable
//  sa_crow  out $clog2(DIM)   C row index
//  sa_cin   out DIM*BITS_C    C row write data
//  sa_cout  in  DIM*BITS_C    C row read data, combinational from sa_crow
// BEHAVIOUR
//  Localparams:
//   - CW    = ceil(DIM*BITS_C/DATAW), the number of words per C row.
//   - RUN_N = 3*DIM-2, the feed-plus-drain cycle count.
//  Address map, with r < DIM and h < CW:
//   - 0x0100+r: A row write.
//   - 0x0200+r: B row write.
//   - 0x0300+r*CW+h: C row r, word h. Word h covers bits [h*DATAW +: DATAW].
//   - 0x0400: CTRL/STATUS.
//   - Any other address: writes are ignored; reads return 0 with rd_valid.
//  A write, IDLE: in the same cycle as bus_en, drive a_wren=1, a_row=r, a_din=dataIn.
//  B write, IDLE: in the same cycle, drive b_en=1, b_din=dataIn.
//  C write, IDLE:
//   - Words h<CW-1 go into a CW*DATAW holding register.
//   - The word h=CW-1 commits the row: sa_wren=1, sa_crow=r, sa_cin=holding register merged with dataIn, truncated to DIM*BITS_C.
//  Reads:
//   - 1-cycle latency: dataOut and rd_valid are registered from the access cycle.
//   - A and B regions are write-only and read as 0.
//   - C read: sa_crow=r in the access cycle; dataOut = word h of sa_cout.
//  CTRL write:
//   - bit0 START (self-clearing) is honoured only in IDLE.
//   - bit1 ACC and bit2 IRQ_EN are stored.
//   - bit8=1 clears DONE; bit9=1 clears ERR.
//  STATUS read: bit0 BUSY, bit1 ACC, bit2 IRQ_EN, bit8 DONE, bit9 ERR, all other bits 0.
//  FSM states IDLE, CLEAR, RUN, FIN:
//   - IDLE -> CLEAR on START with ACC=0.
//   - IDLE -> RUN on START with ACC=1.
//   - CLEAR: DIM cycles; sa_wren=1, sa_cin=0, sa_crow=0..DIM-1; then go to RUN.
//   - RUN: RUN_N cycles with sa_en=1. a_en=1 and b_en=1 only during the first DIM cycles. Then go to FIN.
//   - FIN: one cycle; set DONE=1; go to IDLE.
//   - BUSY=1 in CLEAR, RUN and FIN.
//  Access while BUSY:
//   - A/B/C writes, C reads and START are ignored and set ERR=1; C reads also return 0 with rd_valid=1.
//   - CTRL/STATUS accesses act normally, except START.
//  Simultaneous DONE set (FIN) and a bit8 clear: the set wins.
//  A repeated START while in FIN is an ERR.
//  Reset (rst_n=0 at clk edge), including mid-run:
//   - FSM returns to IDLE; all strobes=0; a_row/sa_crow=0; dataOut=0; rd_valid=0; irq_done=0.
//   - ACC, IRQ_EN, DONE, ERR and the holding register are cleared.
//  Datapath strobes outside the cases above are 0; data outputs are 0 when idle.
// STRUCTURE
//  tpu_pkg holds:
//   - address region constants (A_BASE, B_BASE, C_BASE, CTRL_ADDR);
//   - CTRL/STATUS bit positions;
//   - the seq_state_t enum {IDLE, CLEAR, RUN, FIN}.
//  Bus decode and the FSM live in this module.
//  One sub-module: tpu_seq_cnt, a loadable down-counter with a zero flag, shared by CLEAR and RUN.
// TESTING
//  - Reset, then read 0x0400 -> dataOut=0 one cycle later, rd_valid=1, irq_done=0.
//  - Write 0x0103 data 0x0102030405060708 -> same cycle a_wren=1, a_row=3, a_din=that value.
//  - Write 0x0300 and 0x0301, then read both back -> row 0 equals the written 128 bits; sa_wren pulses only on 0x0301.
//  - Load identity A and B ramp, write CTRL=0x5 (START|IRQ_EN) ->
//    - BUSY for DIM+RUN_N+1 = 31 cycles; sa_en high 22 cycles;
//    - C reads equal the B ramp; DONE=1 and irq_done=1; writing bit8 clears both.
//  - Rerun with ACC=1 -> no CLEAR phase (23 busy cycles); C equals twice the ramp.
//  - A write at 0x0100 during RUN -> ignored, ERR=1; then assert rst_n=0 mid-RUN -> IDLE, all outputs 0, status 0.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - address map, control bit positions and sequencer state type
package tpu_pkg;

  // Word-address bases of the host-visible regions
  localparam int A_BASE    = 'h0100;
  localparam int B_BASE    = 'h0200;
  localparam int C_BASE    = 'h0300;
  localparam int CTRL_ADDR = 'h0400;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_ACC      = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_CLR_DONE = 8;
  localparam int CTRL_CLR_ERR  = 9;

  // STATUS read bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_ACC    = 1;
  localparam int STAT_IRQ_EN = 2;
  localparam int STAT_DONE   = 8;
  localparam int STAT_ERR    = 9;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FIN} seq_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tpu_seq_cnt.sv
// rtl/tpu_seq_cnt.sv - loadable down-counter with zero flag for the CLEAR and RUN phases
module tpu_seq_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load has priority; decrement saturates at zero so the flag stays stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tpu_seq.sv
// rtl/tpu_seq.sv - memory-mapped sequencer driving memA, memB and the systolic array
module tpu_seq
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bus_en,
  input  logic                    r_w,
  input  logic [ADDRW-1:0]        addr,
  input  logic [DATAW-1:0]        dataIn,
  output logic [DATAW-1:0]        dataOut,
  output logic                    rd_valid,
  output logic                    irq_done,
  output logic                    a_en,
  output logic                    a_wren,
  output logic [$clog2(DIM)-1:0]  a_row,
  output logic [DIM*BITS_AB-1:0]  a_din,
  output logic                    b_en,
  output logic [DIM*BITS_AB-1:0]  b_din,
  output logic                    sa_en,
  output logic                    sa_wren,
  output logic [$clog2(DIM)-1:0]  sa_crow,
  output logic [DIM*BITS_C-1:0]   sa_cin,
  input  logic [DIM*BITS_C-1:0]   sa_cout
);

  localparam int CW    = ceil_div(DIM * BITS_C, DATAW);
  localparam int RUN_N = 3 * DIM - 2;
  localparam int RW    = $clog2(DIM);
  localparam int CNTW  = $clog2(RUN_N);
  localparam int HW    = (CW > 1) ? $clog2(CW) : 1;
  localparam int HOLDW = CW * DATAW;

  seq_state_t state, nxt;

  logic [CNTW-1:0]  cnt, load_val;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             acc, irq_en, done, err;
  logic [HOLDW-1:0] hold, merged, cout_ext;
  logic [ADDRW-1:0] a_off, b_off, c_off;
  logic             in_a, in_b, in_c, in_ctrl;
  logic             wr, rd, busy, c_last, start_req, idle_start, err_set;
  logic [RW-1:0]    c_row;
  logic [HW-1:0]    c_word;
  logic [DATAW-1:0] status;

  // Region decode: offsets below a base wrap high and fall outside every window
  assign a_off   = addr - ADDRW'(A_BASE);
  assign b_off   = addr - ADDRW'(B_BASE);
  assign c_off   = addr - ADDRW'(C_BASE);
  assign in_a    = (a_off < ADDRW'(DIM));
  assign in_b    = (b_off < ADDRW'(DIM));
  assign in_c    = (c_off < ADDRW'(DIM * CW));
  assign in_ctrl = (addr == ADDRW'(CTRL_ADDR));
  assign c_row   = RW'(c_off / ADDRW'(CW));
  assign c_word  = HW'(c_off % ADDRW'(CW));
  assign c_last  = (c_word == HW'(CW - 1));

  assign wr         = bus_en & r_w;
  assign rd         = bus_en & ~r_w;
  assign busy       = (state != IDLE);
  assign start_req  = wr & in_ctrl & dataIn[CTRL_START];
  assign idle_start = start_req & ~busy;
  assign err_set    = busy & ((wr & (in_a | in_b | in_c)) | (rd & in_c) | start_req);
  assign irq_done   = done & irq_en;
  assign cout_ext   = HOLDW'(sa_cout);

  // The committing write's word replaces the top slot of the holding register
  always_comb begin
    merged = hold;
    merged[(CW-1)*DATAW +: DATAW] = dataIn;
  end

  // STATUS word assembly
  always_comb begin
    status              = '0;
    status[STAT_BUSY]   = busy;
    status[STAT_ACC]    = acc;
    status[STAT_IRQ_EN] = irq_en;
    status[STAT_DONE]   = done;
    status[STAT_ERR]    = err;
  end

  // Phase counter: CLEAR counts DIM rows, RUN counts feed plus drain cycles
  assign cnt_load = ((state == IDLE) && idle_start) || ((state == CLEAR) && cnt_zero);
  assign load_val = ((state == IDLE) && !dataIn[CTRL_ACC]) ? CNTW'(DIM - 1) : CNTW'(RUN_N - 1);
  assign cnt_dec  = (state == CLEAR) || (state == RUN);

  tpu_seq_cnt #(.W(CNTW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // FSM next-state; ACC for the new run comes from the same CTRL write as START
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (idle_start) nxt = dataIn[CTRL_ACC] ? RUN : CLEAR;
      CLEAR:   if (cnt_zero) nxt = RUN;
      RUN:     if (cnt_zero) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FSM outputs: host-driven strobes in IDLE, autonomous strobes otherwise
  always_comb begin
    a_en    = 1'b0;
    a_wren  = 1'b0;
    a_row   = '0;
    a_din   = '0;
    b_en    = 1'b0;
    b_din   = '0;
    sa_en   = 1'b0;
    sa_wren = 1'b0;
    sa_crow = '0;
    sa_cin  = '0;
    case (state)
      IDLE: begin
        if (wr && in_a) begin
          a_wren = 1'b1;
          a_row  = RW'(a_off);
          a_din  = dataIn;
        end
        if (wr && in_b) begin
          b_en  = 1'b1;
          b_din = dataIn;
        end
        if (bus_en && in_c) begin
          sa_crow = c_row;
          if (r_w && c_last) begin
            sa_wren = 1'b1;
            sa_cin  = merged[DIM*BITS_C-1:0];
          end
        end
      end
      CLEAR: begin
        sa_wren = 1'b1;
        sa_crow = RW'(CNTW'(DIM - 1) - cnt);
      end
      RUN: begin
        sa_en = 1'b1;
        if (cnt >= CNTW'(RUN_N - DIM)) begin
          a_en = 1'b1;
          b_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered read path: one-cycle latency, zero for write-only or blocked regions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOut  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      dataOut  <= '0;
      if (rd) begin
        if (in_c && !busy) dataOut <= cout_ext[c_word*DATAW +: DATAW];
        else if (in_ctrl)  dataOut <= status;
      end
    end
  end

  // C row holding register for the non-final words of a row write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (wr && in_c && !busy && !c_last) begin
      hold[c_word*DATAW +: DATAW] <= dataIn;
    end
  end

  // Control and sticky status; DONE and ERR sets are applied after clears so they win
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= 1'b0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (wr && in_ctrl) begin
        acc    <= dataIn[CTRL_ACC];
        irq_en <= dataIn[CTRL_IRQ_EN];
        if (dataIn[CTRL_CLR_DONE]) done <= 1'b0;
        if (dataIn[CTRL_CLR_ERR])  err  <= 1'b0;
      end
      if (state == FIN) done <= 1'b1;
      if (err_set)      err  <= 1'b1;
    end
  end

endmodule
